// File: rtl/exu_bju_pipe.sv
// Registered branch/jump resolve unit with a valid/ready output stage and flush.
// Define TOYSOC_BJU_BHT_EN to build the 2-bit branch-history counter table and its lookup port.
module exu_bju_pipe #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [7:0]      i_bjuop,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [XLEN-1:0] i_rs1rdata,
  input  logic [XLEN-1:0] i_offset,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_pred_addr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_jump,
  output logic [XLEN-1:0] o_jaddr,
  output logic [XLEN-1:0] o_link,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_addr,
  input  logic [XLEN-1:0] i_lkp_pc,
  output logic            o_lkp_taken
);

  logic            valid_reg, jump_reg, redirect_reg;
  logic [XLEN-1:0] jaddr_reg, link_reg, redirect_addr_reg;
  logic            accept;
  logic            taken, is_cond, is_jalr, mispredict;
  logic [XLEN-1:0] jalr_sum, target, fall_through;

  assign o_ready = ~valid_reg | i_ready;
  assign accept  = i_valid & o_ready;

  // Multi-hot ops resolve by priority, lowest bit first.
  always_comb begin
    taken   = 1'b0;
    is_cond = 1'b0;
    is_jalr = 1'b0;
    if (i_bjuop[0]) begin
      is_cond = 1'b1;
      taken   = (i_op1 == i_op2);
    end else if (i_bjuop[1]) begin
      is_cond = 1'b1;
      taken   = (i_op1 != i_op2);
    end else if (i_bjuop[2]) begin
      is_cond = 1'b1;
      taken   = ($signed(i_op1) < $signed(i_op2));
    end else if (i_bjuop[3]) begin
      is_cond = 1'b1;
      taken   = ($signed(i_op1) >= $signed(i_op2));
    end else if (i_bjuop[4]) begin
      is_cond = 1'b1;
      taken   = (i_op1 < i_op2);
    end else if (i_bjuop[5]) begin
      is_cond = 1'b1;
      taken   = (i_op1 >= i_op2);
    end else if (i_bjuop[6]) begin
      taken   = 1'b1;
    end else if (i_bjuop[7]) begin
      taken   = 1'b1;
      is_jalr = 1'b1;
    end
  end

  assign jalr_sum     = i_rs1rdata + i_offset;
  assign target       = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (i_pc + i_offset);
  assign fall_through = i_pc + XLEN'(4);
  assign mispredict   = (taken != i_pred_taken) | (taken & (target != i_pred_addr));

  // Flush wins over accept; a drained result leaves its data registers as-is.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_reg         <= 1'b0;
      jump_reg          <= 1'b0;
      redirect_reg      <= 1'b0;
      jaddr_reg         <= '0;
      link_reg          <= '0;
      redirect_addr_reg <= '0;
    end else if (i_flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg         <= 1'b1;
      jump_reg          <= taken;
      redirect_reg      <= mispredict;
      jaddr_reg         <= target;
      link_reg          <= fall_through;
      redirect_addr_reg <= taken ? target : fall_through;
    end else if (valid_reg & i_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign o_valid         = valid_reg;
  assign o_jump          = jump_reg;
  assign o_jaddr         = jaddr_reg;
  assign o_link          = link_reg;
  assign o_redirect      = valid_reg & redirect_reg;
  assign o_redirect_addr = redirect_addr_reg;

`ifdef TOYSOC_BJU_BHT_EN
  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0]     upd_idx, lkp_idx;
  logic                 bht_we;
  logic [BHT_DEPTH-1:0] bht_dir;
  logic                 unused_lkp;

  assign upd_idx    = i_pc[IDX_W+1:2];
  assign lkp_idx    = i_lkp_pc[IDX_W+1:2];
  assign bht_we     = accept & ~i_flush & is_cond;
  assign unused_lkp = ^i_lkp_pc;

  genvar gi;
  generate
    for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      logic [1:0] ctr_reg;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ctr_reg <= 2'b01;
        end else if (bht_we && (upd_idx == IDX_W'(gi))) begin
          if (taken && (ctr_reg != 2'b11))
            ctr_reg <= ctr_reg + 2'b01;
          else if (!taken && (ctr_reg != 2'b00))
            ctr_reg <= ctr_reg - 2'b01;
        end
      end
      assign bht_dir[gi] = ctr_reg[1];
    end
  endgenerate

  // Combinational read: a same-cycle update is not visible until the next cycle.
  assign o_lkp_taken = bht_dir[lkp_idx];
`else
  logic unused_bht;
  assign unused_bht  = ^{i_lkp_pc, is_cond};
  assign o_lkp_taken = 1'b0;
`endif

endmodule

// File: tb/tb_exu_bju_pipe.sv
// Randomized and directed bench for exu_bju_pipe against a behavioural reference model.
// Follows TOYSOC_BJU_BHT_EN to pick BHT lookup expectations.
module tb_exu_bju_pipe;
  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
`ifdef TOYSOC_BJU_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst, i_flush, i_valid, i_ready, i_pred_taken;
  logic [7:0]  i_bjuop;
  logic [31:0] i_op1, i_op2, i_rs1rdata, i_offset, i_pc, i_pred_addr, i_lkp_pc;
  logic        o_ready, o_valid, o_jump, o_redirect, o_lkp_taken;
  logic [31:0] o_jaddr, o_link, o_redirect_addr;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic        m_valid, m_jump, m_redir;
  logic [31:0] m_jaddr, m_link, m_raddr;
  int          bht_m [DEPTH];

  always #5 clk = ~clk;

  exu_bju_pipe #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_bjuop(i_bjuop), .i_op1(i_op1), .i_op2(i_op2), .i_rs1rdata(i_rs1rdata),
    .i_offset(i_offset), .i_pc(i_pc), .i_pred_taken(i_pred_taken), .i_pred_addr(i_pred_addr),
    .o_valid(o_valid), .i_ready(i_ready), .o_jump(o_jump), .o_jaddr(o_jaddr), .o_link(o_link),
    .o_redirect(o_redirect), .o_redirect_addr(o_redirect_addr),
    .i_lkp_pc(i_lkp_pc), .o_lkp_taken(o_lkp_taken)
  );

  // Architectural resolve: pick the winning op, then apply its rule.
  function automatic void resolve(input logic [7:0] op, input logic [31:0] a, b, rs1, off, pc,
                                  input logic pt, input logic [31:0] pa,
                                  output logic tk, output logic [31:0] tgt,
                                  output logic mis, output logic is_cond);
    int w;
    w = -1;
    for (int k = 7; k >= 0; k--) if (op[k]) w = k;
    case (w)
      0: tk = (a == b);
      1: tk = (a != b);
      2: tk = ($signed(a) < $signed(b));
      3: tk = ($signed(a) >= $signed(b));
      4: tk = (a < b);
      5: tk = (a >= b);
      6, 7: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    tgt     = (w == 7) ? ((rs1 + off) & 32'hFFFF_FFFE) : (pc + off);
    mis     = (tk != pt) || (tk && (tgt != pa));
    is_cond = (w >= 0) && (w <= 5);
  endfunction

  function automatic logic exp_lkp(input logic [31:0] p);
    return BHT_ON && (bht_m[p[7:2]] >= 2);
  endfunction

  task automatic model_edge();
    logic tk, mis, ic, acc;
    logic [31:0] tgt;
    int idx;
    resolve(i_bjuop, i_op1, i_op2, i_rs1rdata, i_offset, i_pc, i_pred_taken, i_pred_addr,
            tk, tgt, mis, ic);
    acc = i_valid && (!m_valid || i_ready);
    if (i_rst) begin
      m_valid = 0; m_jump = 0; m_redir = 0; m_jaddr = 0; m_link = 0; m_raddr = 0;
      for (int k = 0; k < DEPTH; k++) bht_m[k] = 1;
    end else begin
      if (!i_flush && acc && ic) begin
        idx = int'(i_pc[7:2]);
        if (tk) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
        else    bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
      end
      if (i_flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_jump = tk; m_redir = mis; m_jaddr = tgt;
        m_link = i_pc + 4; m_raddr = tk ? tgt : i_pc + 4;
      end else if (m_valid && i_ready) m_valid = 0;
    end
  endtask

  // Advance one clock; leaves the bench 1 time unit after the rising edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] a, b, rs1, off, pc,
                       input logic pt, input logic [31:0] pa);
    i_bjuop = op; i_op1 = a; i_op2 = b; i_rs1rdata = rs1; i_offset = off;
    i_pc = pc; i_pred_taken = pt; i_pred_addr = pa;
  endtask

  task automatic test_reset();
    i_rst = 1; i_valid = 1; i_ready = 1; i_lkp_pc = 32'h40;
    drive(8'h40, 0, 0, 0, 32'h10, 32'h80, 0, 0);
    tick(); tick();
    i_rst = 0; i_valid = 0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_jump !== 1'b0) begin errors++; $display("FAIL reset_jump: got %b want 0", o_jump); end
    checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", o_redirect); end
    checks++; if (o_jaddr !== 32'h0) begin errors++; $display("FAIL reset_jaddr: got %h want 0", o_jaddr); end
    checks++; if (o_link !== 32'h0) begin errors++; $display("FAIL reset_link: got %h want 0", o_link); end
    checks++; if (o_redirect_addr !== 32'h0) begin errors++; $display("FAIL reset_raddr: got %h want 0", o_redirect_addr); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    checks++; if (o_lkp_taken !== 1'b0) begin errors++; $display("FAIL reset_lkp: got %b want 0", o_lkp_taken); end
  endtask

  task automatic test_branch_compare();
    i_ready = 1;
    drive(8'h04, 32'hFFFF_FFFF, 32'h1, 0, 32'h20, 32'h100, 0, 0);
    i_valid = 1; tick(); i_valid = 0; #1;
    $display("blt  : valid=%b jump=%b jaddr=%h redirect=%b raddr=%h", o_valid, o_jump, o_jaddr, o_redirect, o_redirect_addr);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL blt_valid: got %b want 1", o_valid); end
    checks++; if (o_jump !== 1'b1) begin errors++; $display("FAIL blt_jump: got %b want 1", o_jump); end
    checks++; if (o_jaddr !== 32'h120) begin errors++; $display("FAIL blt_jaddr: got %h want 120", o_jaddr); end
    checks++; if (o_redirect !== 1'b1) begin errors++; $display("FAIL blt_redirect: got %b want 1", o_redirect); end
    checks++; if (o_redirect_addr !== 32'h120) begin errors++; $display("FAIL blt_raddr: got %h want 120", o_redirect_addr); end
    drive(8'h10, 32'hFFFF_FFFF, 32'h1, 0, 32'h20, 32'h100, 0, 0);
    i_valid = 1; tick(); i_valid = 0; #1;
    $display("bltu : valid=%b jump=%b redirect=%b raddr=%h", o_valid, o_jump, o_redirect, o_redirect_addr);
    checks++; if (o_jump !== 1'b0) begin errors++; $display("FAIL bltu_jump: got %b want 0", o_jump); end
    checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL bltu_redirect: got %b want 0", o_redirect); end
    checks++; if (o_redirect_addr !== 32'h104) begin errors++; $display("FAIL bltu_raddr: got %h want 104", o_redirect_addr); end
    tick();
  endtask

  task automatic test_jalr();
    i_ready = 1;
    drive(8'h80, 0, 0, 32'h1001, 32'h4, 32'h200, 1, 32'h1004);
    i_valid = 1; tick(); i_valid = 0; #1;
    $display("jalr : jump=%b jaddr=%h link=%h redirect=%b", o_jump, o_jaddr, o_link, o_redirect);
    checks++; if (o_jaddr !== 32'h1004) begin errors++; $display("FAIL jalr_jaddr: got %h want 1004", o_jaddr); end
    checks++; if (o_link !== 32'h204) begin errors++; $display("FAIL jalr_link: got %h want 204", o_link); end
    checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL jalr_redirect: got %b want 0", o_redirect); end
    drive(8'h80, 0, 0, 32'h1001, 32'h4, 32'h200, 1, 32'h1000);
    i_valid = 1; tick(); i_valid = 0; #1;
    $display("jalr : jump=%b jaddr=%h redirect=%b raddr=%h", o_jump, o_jaddr, o_redirect, o_redirect_addr);
    checks++; if (o_redirect !== 1'b1) begin errors++; $display("FAIL jalr_mis_redirect: got %b want 1", o_redirect); end
    checks++; if (o_redirect_addr !== 32'h1004) begin errors++; $display("FAIL jalr_mis_raddr: got %h want 1004", o_redirect_addr); end
    tick();
  endtask

  task automatic test_back_to_back();
    i_ready = 0;
    drive(8'h01, 32'h5, 32'h5, 0, 32'h8, 32'h300, 1, 32'h308);
    i_valid = 1; tick();
    drive(8'h01, 32'h1, 32'h2, 0, 32'h10, 32'h400, 0, 0);
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", o_ready); end
    for (int c = 0; c < 3; c++) begin
      $display("hold %0d: valid=%b jaddr=%h ready=%b", c, o_valid, o_jaddr, o_ready);
      checks++; if (o_valid !== 1'b1 || o_jaddr !== 32'h308 || o_jump !== 1'b1)
        begin errors++; $display("FAIL bp_hold%0d: got valid=%b jaddr=%h want 1/308", c, o_valid, o_jaddr); end
      tick();
    end
    i_ready = 1; #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_high: got %b want 1", o_ready); end
    tick(); i_valid = 0; #1;
    $display("drain: valid=%b jump=%b jaddr=%h link=%h", o_valid, o_jump, o_jaddr, o_link);
    checks++; if (o_valid !== 1'b1 || o_jump !== 1'b0 || o_link !== 32'h404 || o_jaddr !== 32'h410)
      begin errors++; $display("FAIL bp_second: got valid=%b jump=%b link=%h jaddr=%h want 1/0/404/410", o_valid, o_jump, o_link, o_jaddr); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", o_valid); end
  endtask

  task automatic test_flush();
    i_rst = 1; tick(); i_rst = 0;
    i_ready = 1; i_flush = 1; i_lkp_pc = 32'h80;
    drive(8'h01, 32'h7, 32'h7, 0, 32'h10, 32'h80, 0, 0);
    i_valid = 1; tick(); i_valid = 0; i_flush = 0; #1;
    $display("flush: valid=%b lkp=%b", o_valid, o_lkp_taken);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", o_valid); end
    checks++; if (o_lkp_taken !== 1'b0) begin errors++; $display("FAIL flush_bht: got %b want 0", o_lkp_taken); end
    i_ready = 0; i_valid = 1; tick(); i_valid = 0; #1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL flush_held: got %b want 1", o_valid); end
    i_flush = 1; tick(); i_flush = 0; #1;
    $display("flush held: valid=%b", o_valid);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b want 0", o_valid); end
    i_ready = 1;
  endtask

  task automatic test_bht();
    logic pre_t[3] = '{1'b0, 1'b1, 1'b1};
    logic pre_n[2] = '{1'b1, 1'b1};
    i_rst = 1; tick(); i_rst = 0;
    i_ready = 1; i_lkp_pc = 32'h40;
    drive(8'h02, 32'h1, 32'h2, 0, 32'h10, 32'h40, 0, 0);
    for (int k = 0; k < 3; k++) begin
      i_valid = 1; #1;
      $display("bht taken %0d: lkp=%b", k, o_lkp_taken);
      checks++; if (o_lkp_taken !== (BHT_ON & pre_t[k])) begin errors++; $display("FAIL bht_t%0d: got %b want %b", k, o_lkp_taken, BHT_ON & pre_t[k]); end
      tick();
      checks++; if (o_jump !== 1'b1 || o_jaddr !== 32'h50) begin errors++; $display("FAIL bht_res%0d: got jump=%b jaddr=%h want 1/50", k, o_jump, o_jaddr); end
    end
    i_op2 = 32'h1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (o_lkp_taken !== (BHT_ON & pre_n[k])) begin errors++; $display("FAIL bht_n%0d: got %b want %b", k, o_lkp_taken, BHT_ON & pre_n[k]); end
      tick();
    end
    i_valid = 0; #1;
    $display("bht after not-taken: lkp=%b", o_lkp_taken);
    checks++; if (o_lkp_taken !== 1'b0) begin errors++; $display("FAIL bht_back0: got %b want 0", o_lkp_taken); end
    i_op2 = 32'h2; i_valid = 1; tick(); tick(); i_valid = 0; #1;
    checks++; if (o_lkp_taken !== BHT_ON) begin errors++; $display("FAIL bht_retrain: got %b want %b", o_lkp_taken, BHT_ON); end
    i_rst = 1; tick(); i_rst = 0; #1;
    $display("bht after reset: lkp=%b", o_lkp_taken);
    checks++; if (o_lkp_taken !== 1'b0) begin errors++; $display("FAIL bht_reset: got %b want 0", o_lkp_taken); end
  endtask

  task automatic test_random();
    logic tk, mis, ic;
    logic [31:0] tgt, r;
    i_rst = 1; tick(); i_rst = 0;
    for (int n = 0; n < 3000; n++) begin
      i_rst   = ($urandom_range(0, 199) == 0);
      i_flush = ($urandom_range(0, 19) == 0);
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 7))
        6: i_bjuop = 8'($urandom);
        7: i_bjuop = 8'h00;
        default: i_bjuop = 8'(1 << $urandom_range(0, 7));
      endcase
      i_op1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
      i_op2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
      i_rs1rdata = $urandom;
      r = $urandom; i_offset = {{20{r[11]}}, r[11:0]};
      i_pc = {$urandom_range(0, 1023), 2'b00};
      i_lkp_pc = $urandom_range(0, 1) ? i_pc : $urandom;
      i_pred_taken = $urandom_range(0, 1);
      resolve(i_bjuop, i_op1, i_op2, i_rs1rdata, i_offset, i_pc, 1'b0, 32'h0, tk, tgt, mis, ic);
      i_pred_addr = $urandom_range(0, 1) ? tgt : $urandom;
      #1;
      if (n % 250 == 0)
        $display("rand %0d: valid=%b ready=%b jump=%b jaddr=%h redirect=%b lkp=%b", n, o_valid, o_ready, o_jump, o_jaddr, o_redirect, o_lkp_taken);
      checks++; if (o_ready !== (!m_valid || i_ready)) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, o_ready, !m_valid || i_ready); end
      checks++; if (o_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, o_valid, m_valid); end
      checks++; if (o_redirect !== (m_valid && m_redir)) begin errors++; $display("FAIL rnd_redirect@%0d: got %b want %b", n, o_redirect, m_valid && m_redir); end
      checks++; if (o_jump !== m_jump) begin errors++; $display("FAIL rnd_jump@%0d: got %b want %b", n, o_jump, m_jump); end
      checks++; if (o_jaddr !== m_jaddr) begin errors++; $display("FAIL rnd_jaddr@%0d: got %h want %h", n, o_jaddr, m_jaddr); end
      checks++; if (o_link !== m_link) begin errors++; $display("FAIL rnd_link@%0d: got %h want %h", n, o_link, m_link); end
      checks++; if (o_redirect_addr !== m_raddr) begin errors++; $display("FAIL rnd_raddr@%0d: got %h want %h", n, o_redirect_addr, m_raddr); end
      checks++; if (o_lkp_taken !== exp_lkp(i_lkp_pc)) begin errors++; $display("FAIL rnd_lkp@%0d: got %b want %b", n, o_lkp_taken, exp_lkp(i_lkp_pc)); end
      tick();
    end
    i_rst = 0; i_flush = 0; i_valid = 0;
  endtask

  initial begin
    m_valid = 0; m_jump = 0; m_redir = 0; m_jaddr = 0; m_link = 0; m_raddr = 0;
    for (int k = 0; k < DEPTH; k++) bht_m[k] = 1;
    i_rst = 1; i_flush = 0; i_valid = 0; i_ready = 1; i_lkp_pc = 0;
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_branch_compare();
    test_jalr();
    test_back_to_back();
    test_flush();
    test_bht();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exu_bju_pipe.md
# exu_bju_pipe

Parametrised, registered branch/jump unit for the EXU stage. Resolves conditional branches, JAL and JALR, checks the outcome against the IFU's prediction and produces a registered redirect request one cycle after acceptance. A valid/ready output stage and a flush input let it sit in a stallable pipeline. An optional table of 2-bit branch-history counters is trained on every resolved conditional branch and exposes a combinational lookup port to the IFU.

## Interface
- XLEN, 32, datapath width; must be ≥ 8.
- BHT_DEPTH, 64, number of history counters; power of two, ≥ 2.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  kill the held result and discard the current input.
- i_valid  in  1  input request valid.
- o_ready  out  1  input accepted this cycle when i_valid & o_ready.
- i_bjuop  in  8  one-hot op, bit 0..7 = beq, bne, blt, bge, bltu, bgeu, jal, jalr.
- i_op1, i_op2  in  XLEN  compare operands.
- i_rs1rdata  in  XLEN  JALR base.
- i_offset  in  XLEN  sign-extended immediate.
- i_pc  in  XLEN  instruction PC.
- i_pred_taken  in  1  IFU prediction.
- i_pred_addr  in  XLEN  IFU predicted target.
- o_valid  out  1  registered result valid.
- i_ready  in  1  downstream accepts the result.
- o_jump  out  1  resolved taken.
- o_jaddr  out  XLEN  resolved target.
- o_link  out  XLEN  i_pc + 4, the rd writeback for jal/jalr.
- o_redirect  out  1  misprediction; the front end must refetch.
- o_redirect_addr  out  XLEN  refetch PC.
- i_lkp_pc  in  XLEN  IFU lookup PC.
- o_lkp_taken  out  1  predicted direction for i_lkp_pc.

## Operation
- Condition: beq/bne compare equality; blt/bge compare signed; bltu/bgeu compare unsigned.
  - Multi-hot i_bjuop resolves by priority, bit 0 highest.
  - All-zero i_bjuop resolves not-taken.
- taken = condition result, or 1 for jal/jalr.
- Target:
  - jalr: (i_rs1rdata + i_offset) with bit 0 cleared.
  - All others: i_pc + i_offset.
  - All sums are modulo 2^XLEN.
- Fall-through = i_pc + 4.
- mispredict = (taken ≠ i_pred_taken) | (taken & target ≠ i_pred_addr).
- o_redirect_addr = taken ? target : fall-through.
- Output stage:
  - o_ready = ~o_valid | i_ready.
  - On accept without flush: all result registers load and o_valid ← 1.
  - If o_valid & i_ready and there is no accept, o_valid ← 0.
  - o_redirect is qualified: it is 0 whenever o_valid is 0.
- Flush: o_valid ← 0 next cycle. An input presented in the same cycle is discarded and does not train the BHT. Flush has priority over accept.
- BHT (when compiled in):
  - Index = pc[log2(BHT_DEPTH)+1 : 2].
  - Updates only on an accepted (non-flushed) conditional branch.
  - Counter increments on taken and decrements on not-taken, saturating at 3 and 0.
  - jal, jalr and zero-op accepts leave the BHT unchanged.
  - o_lkp_taken = counter[index(i_lkp_pc)][1].

## Timing
- Result latency is 1 cycle: accept at edge N gives o_valid high after edge N.
- Throughput is 1/cycle while i_ready = 1.
- When o_valid & ~i_ready, the held result stays stable until accepted.
- o_ready depends combinationally on i_ready, with no other input path.
- BHT lookup is combinational. A same-cycle lookup and update of one index returns the pre-update value.
- Reset:
  - o_valid, o_jump, o_redirect = 0.
  - o_jaddr, o_link, o_redirect_addr = 0.
  - All BHT counters = 2'b01 (weakly not-taken), so o_lkp_taken = 0.
  - Reset asserted mid-stream drops the held result and ignores inputs in that cycle.

## Configuration
- TOYSOC_BJU_BHT_EN defined: the BHT counter storage and update logic are built as above.
- Not defined: no counter storage; o_lkp_taken is tied to 0, i_lkp_pc is unused, and BHT_DEPTH is ignored. All other behaviour is identical.

## Test plan
- Branch compares:
  - blt, op1=32'hFFFF_FFFF, op2=1, pc=0x100, offset=0x20, pred_taken=0 → next cycle o_jump=1, o_jaddr=0x120, o_redirect=1, o_redirect_addr=0x120.
  - Same case as bltu → o_jump=0, o_redirect=0.
- jalr, rs1rdata=0x1001, offset=4, pc=0x200, pred_taken=1, pred_addr=0x1004 → o_jaddr=0x1004, o_link=0x204, o_redirect=0.
  - With pred_addr=0x1000 → o_redirect=1.
- Backpressure: two back-to-back beq accepts while i_ready=0.
  - Second input sees o_ready=0 and is held.
  - First result stays stable for 3 cycles, then drains on i_ready=1; the second follows one cycle later.
- Flush: i_flush=1 together with a valid beq → o_valid=0 next cycle, and the BHT entry is unchanged.
  - A held result is dropped when i_flush is asserted.
- BHT (macro on), taken bne at pc=0x40 repeated:
  - Counter index 16 goes 1→2→3→3.
  - o_lkp_taken for 0x40 rises after the first update; two not-taken resolves return it to 0.
  - Reset restores 01.
- Macro off: the same stimulus keeps o_lkp_taken=0 throughout, and the resolve results are identical.
